// File: rtl/tt_nibble_serializer.sv
// rtl/tt_nibble_serializer.sv - nibble-to-byte assembler, small byte FIFO and MSB-first serial feeder
module tt_nibble_serializer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = WIDTH / 2;
   localparam int BW = $clog2(WIDTH);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   logic          clk;
   logic          rst_n;
   logic          nib_ld;
   logic          run;
   logic [HW-1:0] nib;

   assign clk    = io_in[0];
   assign rst_n  = io_in[1];
   assign nib_ld = io_in[2];
   assign run    = io_in[3];
   assign nib    = io_in[7:4];

   logic             nib_ld_q;
   logic             phase_lo_q, phase_lo_d;
   logic [HW-1:0]    hi_q, hi_d;
   logic             push_q, push_d;
   logic [WIDTH-1:0] push_data_q, push_data_d;
   logic             load_ev;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             full;
   logic             wr_en;
   logic             pop;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;

   assign load_ev = nib_ld & ~nib_ld_q;

   // The assembled byte is pushed one cycle after the second nibble's load edge.
   always_comb begin
      phase_lo_d  = phase_lo_q;
      hi_d        = hi_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      if (load_ev) begin
         if (!phase_lo_q) begin
            hi_d       = nib;
            phase_lo_d = 1'b1;
         end else begin
            push_d      = 1'b1;
            push_data_d = {hi_q, nib};
            phase_lo_d  = 1'b0;
         end
      end
   end

   assign full  = (count_q == CW'(DEPTH));
   assign wr_en = push_q & (~full | pop);

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      ovf_d    = ovf_q | (push_q & full & ~pop);
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run && count_q != '0) begin
               pop       = 1'b1;
               shreg_d   = mem_q[rd_ptr_q];
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(WIDTH - 1)) begin
               bit_cnt_d = bit_cnt_q;
               // Reload on the last bit keeps consecutive bytes gap-free.
               if (run && count_q != '0) begin
                  pop       = 1'b1;
                  shreg_d   = mem_q[rd_ptr_q];
                  bit_cnt_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nib_ld_q    <= 1'b0;
         phase_lo_q  <= 1'b0;
         hi_q        <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
      end else begin
         nib_ld_q    <= nib_ld;
         phase_lo_q  <= phase_lo_d;
         hi_q        <= hi_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
      end
   end

   assign io_out[0]   = (state_q == S_SHIFT) & shreg_q[WIDTH-1];
   assign io_out[1]   = (state_q == S_SHIFT);
   assign io_out[2]   = (state_q == S_IDLE);
   assign io_out[3]   = (state_q == S_SHIFT) & (bit_cnt_q == '0);
   assign io_out[6:4] = 3'(count_q);
   assign io_out[7]   = ovf_q;

endmodule

// File: tb/tb_tt_nibble_serializer.sv
// tb/tb_tt_nibble_serializer.sv - directed and randomized checks of tt_nibble_serializer against a queue model
module tb_tt_nibble_serializer;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic       nib_ld;
   logic       run;
   logic [3:0] nib;
   wire  [7:0] io_in;
   wire  [7:0] io_out;

   int tests = 0;
   int fails = 0;

   assign io_in = {nib, run, nib_ld, rst_n, clk};

   tt_nibble_serializer #(.DEPTH(DEPTH), .WIDTH(8)) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: bytes live in a queue, the serializer is "which byte, which bit".
   logic       m_ld_prev;
   logic       m_phase_lo;
   logic [3:0] m_hi;
   logic       m_pend;
   logic [7:0] m_pend_byte;
   logic [7:0] m_fifo[$];
   logic       m_ovf;
   logic       m_active;
   logic [7:0] m_cur;
   int         m_idx;

   task automatic model_reset();
      m_ld_prev  = 1'b0;
      m_phase_lo = 1'b0;
      m_hi       = '0;
      m_pend     = 1'b0;
      m_pend_byte = '0;
      m_fifo.delete();
      m_ovf      = 1'b0;
      m_active   = 1'b0;
      m_cur      = '0;
      m_idx      = 0;
   endtask

   task automatic model_step();
      logic       ev;
      logic       do_pop;
      logic [7:0] popped;
      if (!rst_n) begin
         model_reset();
         return;
      end
      popped = '0;
      ev = nib_ld && !m_ld_prev;
      m_ld_prev = nib_ld;
      do_pop = run && (m_fifo.size() > 0) && (!m_active || m_idx == 7);
      if (do_pop) popped = m_fifo.pop_front();
      if (m_pend) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend_byte);
         else m_ovf = 1'b1;
      end
      m_pend = 1'b0;
      if (ev) begin
         if (!m_phase_lo) begin
            m_hi = nib;
            m_phase_lo = 1'b1;
         end else begin
            m_pend = 1'b1;
            m_pend_byte = {m_hi, nib};
            m_phase_lo = 1'b0;
         end
      end
      if (m_active) begin
         if (m_idx == 7) begin
            if (do_pop) begin
               m_cur = popped;
               m_idx = 0;
            end else begin
               m_active = 1'b0;
            end
         end else begin
            m_idx++;
         end
      end else if (do_pop) begin
         m_active = 1'b1;
         m_cur = popped;
         m_idx = 0;
      end
   endtask

   function automatic logic [7:0] model_out();
      logic d;
      d = m_active ? m_cur[7 - m_idx] : 1'b0;
      return {m_ovf, 3'(m_fifo.size()), m_active && m_idx == 0, !m_active, m_active, d};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) chk("cycle_vs_model", {24'd0, io_out}, {24'd0, model_out()});
   end

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic load_nib(input logic [3:0] n);
      nib = n;
      nib_ld = 1'b1;
      step();
      nib_ld = 1'b0;
      step();
   endtask

   task automatic grab(input int n, output logic [31:0] d, output logic [31:0] m, output logic [31:0] s);
      d = '0; m = '0; s = '0;
      for (int i = 0; i < n; i++) begin
         step();
         d = {d[30:0], io_out[0]};
         m = {m[30:0], io_out[3]};
         s = {s[30:0], io_out[1]};
      end
   endtask

   initial begin
      logic [31:0] d, m, s, d2, m2, s2;
      int seen;
      rst_n = 1'b0; nib_ld = 1'b0; run = 1'b0; nib = '0;
      model_reset();
      step(); step();
      chk("reset_outputs", {24'd0, io_out}, 32'h04);
      rst_n = 1'b1;
      step();

      // 0xA5 single byte
      run = 1'b1;
      load_nib(4'hA); load_nib(4'h5);
      chk("a5_count_after_push", {29'd0, io_out[6:4]}, 32'd1);
      chk("a5_idle_before", {30'd0, io_out[2:1]}, 32'b10);
      grab(8, d, m, s);
      chk("a5_data", d[7:0], 32'hA5);
      chk("a5_mark", m[7:0], 32'h80);
      chk("a5_step", s[7:0], 32'hFF);
      step();
      chk("a5_idle_after", {29'd0, io_out[6:4], io_out[2:1]}, 32'b00010);

      // two bytes back to back
      run = 1'b0;
      load_nib(4'h3); load_nib(4'hC); load_nib(4'hF); load_nib(4'h0);
      step();
      chk("b2b_count", {29'd0, io_out[6:4]}, 32'd2);
      run = 1'b1;
      grab(16, d, m, s);
      chk("b2b_data", d[15:0], 32'h3CF0);
      chk("b2b_mark", m[15:0], 32'h8080);
      chk("b2b_step", s[15:0], 32'hFFFF);
      step();
      chk("b2b_idle", {30'd0, io_out[2:1]}, 32'b10);

      // overflow with five bytes into four entries
      run = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         load_nib(4'(b)); load_nib(4'(b));
      end
      step();
      chk("ovf_count_full", {29'd0, io_out[6:4]}, 32'd4);
      chk("ovf_flag", {31'd0, io_out[7]}, 32'd1);
      run = 1'b1;
      grab(32, d, m, s);
      chk("ovf_data", d, 32'h11223344);
      chk("ovf_step", s, 32'hFFFFFFFF);
      step();
      chk("ovf_drained", {27'd0, io_out[7:4], io_out[1]}, 32'b10000);

      // asynchronous reset mid-byte
      load_nib(4'hA); load_nib(4'h5);
      grab(3, d, m, s);
      chk("rst_first_bits", d[2:0], 32'b101);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_async_outputs", {24'd0, io_out}, 32'h04);
      step(); step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (io_out[1]) seen++;
      end
      chk("rst_no_resume", seen, 32'd0);
      chk("rst_count", {29'd0, io_out[6:4]}, 32'd0);

      // held strobe gives one event
      run = 1'b0; nib = 4'h7; nib_ld = 1'b1;
      repeat (10) step();
      nib_ld = 1'b0;
      step();
      chk("hold_count", {29'd0, io_out[6:4]}, 32'd0);
      load_nib(4'h9);
      step();
      chk("hold_phase_low", {29'd0, io_out[6:4]}, 32'd1);
      run = 1'b1;
      grab(8, d, m, s);
      chk("hold_byte", d[7:0], 32'h79);
      step();

      // run dropped mid-byte
      run = 1'b0;
      load_nib(4'h8); load_nib(4'h1); load_nib(4'h4); load_nib(4'h2);
      step();
      run = 1'b1;
      grab(2, d, m, s);
      run = 1'b0;
      grab(6, d2, m2, s2);
      chk("drop_data", {24'd0, d[1:0], d2[5:0]}, 32'h81);
      chk("drop_step", {24'd0, s[1:0], s2[5:0]}, 32'hFF);
      step(); step();
      chk("drop_idle_count", {29'd0, io_out[6:4], io_out[1]}, 32'b0010);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         nib_ld = ($urandom_range(0, 2) == 0);
         run    = ($urandom_range(0, 3) != 0);
         nib    = 4'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            model_reset();
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
